// File: rtl/fetch_queue.sv
// 3-wide fetch packet queue between PC/I-cache and decode, with optional B/BL pre-decode redirect.
// Optional feature macro: PREDECODE_JUMP_EN (undefined: no redirect, every packet stored with all slots valid).
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_fetch,
  input  logic [2:0][31:0] pc_in,
  input  logic [2:0][31:0] inst_in,
  input  logic             flush_fq,
  output logic             isJump_pre,
  output logic [31:0]      target_jump_pre,
  output logic             stall_pc,
  input  logic             ready_dec,
  output logic             valid_dec,
  output logic [2:0][31:0] pc_dec,
  output logic [2:0][31:0] inst_dec,
  output logic [2:0]       slot_valid_dec
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]          r_rd_ptr;
  logic [AW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic [2:0][31:0]       r_pc   [DEPTH];
  logic [2:0][31:0]       r_inst [DEPTH];
  logic [2:0]             r_sv   [DEPTH];

  logic                   w_full;
  logic                   w_valid;
  logic                   w_push;
  logic                   w_pop;
  logic [2:0]             w_slot_sv;

  // Handshake: the head packet transfers on a rising edge where valid_dec && ready_dec and no flush.
  // stall_pc is derived from registered occupancy only, so a pop never frees a slot in the same cycle.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_push  = valid_fetch & ~w_full & ~flush_fq;
  assign w_pop   = w_valid & ready_dec & ~flush_fq;

`ifdef PREDECODE_JUMP_EN
  logic [2:0]  w_jmp;
  logic [25:0] w_offs;
  logic [31:0] w_base;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_jmp[i] = (inst_in[i][31:26] == 6'b010100) | (inst_in[i][31:26] == 6'b010101);
    end
    w_base    = pc_in[0];
    w_offs    = {inst_in[0][9:0], inst_in[0][25:10]};
    w_slot_sv = 3'b111;
    // The first jump wins; younger slots behind it are squashed.
    if (w_jmp[0]) begin
      w_base    = pc_in[0];
      w_offs    = {inst_in[0][9:0], inst_in[0][25:10]};
      w_slot_sv = 3'b001;
    end else if (w_jmp[1]) begin
      w_base    = pc_in[1];
      w_offs    = {inst_in[1][9:0], inst_in[1][25:10]};
      w_slot_sv = 3'b011;
    end else if (w_jmp[2]) begin
      w_base    = pc_in[2];
      w_offs    = {inst_in[2][9:0], inst_in[2][25:10]};
      w_slot_sv = 3'b111;
    end
  end

  assign isJump_pre      = w_push & (|w_jmp);
  assign target_jump_pre = isJump_pre ? (w_base + {{4{w_offs[25]}}, w_offs, 2'b00}) : 32'h0;
`else
  assign isJump_pre      = 1'b0;
  assign target_jump_pre = 32'h0;
  assign w_slot_sv       = 3'b111;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_sv[i] <= 3'b000;
    end else if (flush_fq) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_sv[i] <= 3'b000;
    end else begin
      // Push and pop never target the same entry: pop needs count>0, push needs count<DEPTH.
      if (w_pop) begin
        r_sv[r_rd_ptr] <= 3'b000;
        r_rd_ptr       <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_sv[r_wr_ptr] <= w_slot_sv;
        r_wr_ptr       <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: the head outputs are gated by valid_dec.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]   <= pc_in;
      r_inst[r_wr_ptr] <= inst_in;
    end
  end

  assign stall_pc       = w_full;
  assign valid_dec      = w_valid;
  assign pc_dec         = w_valid ? r_pc[r_rd_ptr]   : '0;
  assign inst_dec       = w_valid ? r_inst[r_rd_ptr] : '0;
  assign slot_valid_dec = w_valid ? r_sv[r_rd_ptr]   : 3'b000;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed packets, expected entries queued at issue, monitor compares on pop.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int W     = 3 + 96 + 96;
`ifdef PREDECODE_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  localparam logic [31:0] NOP   = 32'h0340_0000;
  localparam logic [31:0] B_P40 = 32'h5000_4000;  // B, offs26=0x10 -> +0x40
  localparam logic [31:0] B_M8  = 32'h53FF_FBFF;  // B, offs26=0x3FFFFFE -> -8
  localparam logic [31:0] BL_P4 = 32'h5400_0400;  // BL, offs26=1 -> +4
  localparam logic [31:0] BL_0  = 32'h5400_0000;  // BL, offs26=0

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_fetch;
  logic [2:0][31:0] pc_in;
  logic [2:0][31:0] inst_in;
  logic             flush_fq;
  logic             isJump_pre;
  logic [31:0]      target_jump_pre;
  logic             stall_pc;
  logic             ready_dec;
  logic             valid_dec;
  logic [2:0][31:0] pc_dec;
  logic [2:0][31:0] inst_dec;
  logic [2:0]       slot_valid_dec;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_fetch(valid_fetch), .pc_in(pc_in), .inst_in(inst_in),
    .flush_fq(flush_fq), .isJump_pre(isJump_pre), .target_jump_pre(target_jump_pre),
    .stall_pc(stall_pc), .ready_dec(ready_dec), .valid_dec(valid_dec), .pc_dec(pc_dec),
    .inst_dec(inst_dec), .slot_valid_dec(slot_valid_dec)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one packet for one cycle; expectations are given for the pre-decode-enabled build.
  task automatic send(input logic [31:0] pc0, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] i2, input bit acc, input bit j_on,
                      input logic [31:0] t_on, input logic [2:0] sv_on, input string name);
    bit          ej;
    logic [31:0] et;
    logic [2:0]  esv;
    ej  = JEN ? j_on : 1'b0;
    et  = ej ? t_on : 32'h0;
    esv = JEN ? sv_on : 3'b111;
    valid_fetch = 1'b1;
    pc_in       = {pc0 + 32'd8, pc0 + 32'd4, pc0};
    inst_in     = {i2, i1, i0};
    #1;
    check({name, "_isjump"}, {31'b0, isJump_pre}, {31'b0, ej});
    check({name, "_target"}, target_jump_pre, et);
    if (acc) exp_q.push_back({esv, pc_in, inst_in});
    @(posedge clk);
    #1;
    valid_fetch = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && !flush_fq && valid_dec && ready_dec) begin
      n_checks++;
      mon_act = {slot_valid_dec, pc_dec, inst_dec};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor_unexpected: got packet pc0 %h, expected no packet", pc_dec[0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL monitor_pkt: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; valid_fetch = 1'b0; pc_in = '0; inst_in = '0; flush_fq = 1'b0; ready_dec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_dec", {31'b0, valid_dec}, 32'd0);
    check("rst_stall_pc", {31'b0, stall_pc}, 32'd0);
    check("rst_isjump", {31'b0, isJump_pre}, 32'd0);
    check("rst_slot_valid", {29'b0, slot_valid_dec}, 32'd0);
    check("rst_pc_dec0", pc_dec[0], 32'd0);
    check("rst_inst_dec2", inst_dec[2], 32'd0);
    rst = 1'b1;
    tick();

    // pre-decode patterns, drained immediately
    ready_dec = 1'b1;
    send(32'h1C00, NOP, B_P40, NOP, 1'b1, 1'b1, 32'h0000_1C44, 3'b011, "jump_slot1");
    send(32'h0004, B_M8, NOP, NOP, 1'b1, 1'b1, 32'hFFFF_FFFC, 3'b001, "neg_wrap");
    send(32'h2000, NOP, BL_P4, B_P40, 1'b1, 1'b1, 32'h0000_2008, 3'b011, "first_of_two");
    send(32'h3000, NOP, NOP, BL_0, 1'b1, 1'b1, 32'h0000_3008, 3'b111, "bl_slot2");
    send(32'h4000, NOP, NOP, NOP, 1'b1, 1'b0, 32'h0, 3'b111, "no_jump");
    tick();
    check("drain_count", 32'(dut.r_count), 32'd0);

    // fill, drop while full, pop from full, refill with wrap, push+pop
    ready_dec = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      send(32'h5000 + 32'(k * 16), 32'h100 + 32'(k), NOP, NOP, 1'b1, 1'b0, 32'h0, 3'b111, "fill");
    check("fill_stall", {31'b0, stall_pc}, 32'd1);
    check("fill_count", 32'(dut.r_count), 32'd4);
    send(32'h6000, B_P40, NOP, NOP, 1'b0, 1'b0, 32'h0, 3'b001, "full_drop");
    check("drop_count", 32'(dut.r_count), 32'd4);
    check("drop_stall", {31'b0, stall_pc}, 32'd1);
    ready_dec = 1'b1;
    send(32'h6000, B_P40, NOP, NOP, 1'b0, 1'b0, 32'h0, 3'b001, "pop_from_full");
    ready_dec = 1'b0;
    check("pop_full_stall", {31'b0, stall_pc}, 32'd0);
    check("pop_full_count", 32'(dut.r_count), 32'd3);
    send(32'h6000, B_P40, NOP, NOP, 1'b1, 1'b1, 32'h0000_6040, 3'b001, "refill");
    check("refill_stall", {31'b0, stall_pc}, 32'd1);
    ready_dec = 1'b1;
    tick();
    send(32'h7000, NOP, NOP, NOP, 1'b1, 1'b0, 32'h0, 3'b111, "push_pop");
    check("push_pop_count", 32'(dut.r_count), 32'd3);
    repeat (4) tick();
    check("fill_drained_valid", {31'b0, valid_dec}, 32'd0);

    // flush with incoming jump and ready_dec high
    ready_dec = 1'b0;
    for (int k = 0; k < 3; k++)
      send(32'h8000 + 32'(k * 16), NOP, 32'h200 + 32'(k), NOP, 1'b1, 1'b0, 32'h0, 3'b111, "preflush");
    flush_fq  = 1'b1;
    ready_dec = 1'b1;
    send(32'h9000, B_P40, NOP, NOP, 1'b0, 1'b0, 32'h0, 3'b001, "flush_in");
    flush_fq  = 1'b0;
    ready_dec = 1'b0;
    exp_q.delete();
    check("flush_valid_dec", {31'b0, valid_dec}, 32'd0);
    check("flush_count", 32'(dut.r_count), 32'd0);
    ready_dec = 1'b1;
    send(32'hA000, NOP, NOP, B_P40, 1'b1, 1'b1, 32'h0000_A048, 3'b111, "post_flush");
    tick();

    // asynchronous reset with traffic queued (queue full, so stall_pc drops too)
    ready_dec = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      send(32'hB000 + 32'(k * 16), NOP, NOP, 32'h300 + 32'(k), 1'b1, 1'b0, 32'h0, 3'b111, "prereset");
    rst = 1'b0;
    #1;
    check("midrst_valid_dec", {31'b0, valid_dec}, 32'd0);
    check("midrst_stall_pc", {31'b0, stall_pc}, 32'd0);
    check("midrst_slot_valid", {29'b0, slot_valid_dec}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("postrst_count", 32'(dut.r_count), 32'd0);
    ready_dec = 1'b1;
    send(32'hC000, B_M8, NOP, NOP, 1'b1, 1'b1, 32'h0000_BFF8, 3'b001, "post_reset");
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
